// File: rtl/mycpu_io_port.sv
// I/O responder for the mycpu core: IOR drains an input byte FIFO, IOW fills an
// output byte FIFO, and the CPU is held off through io_req/io_ack while a FIFO cannot serve.
module mycpu_io_port #(
   parameter int N     = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         io_req,
   input  logic                         io_we,
   input  logic [N-1:0]                 io_wdata,
   output logic [N-1:0]                 io_rdata,
   output logic                         io_ack,
   input  logic                         in_valid,
   input  logic [N-1:0]                 in_data,
   output logic                         in_ready,
   output logic                         out_valid,
   output logic [N-1:0]                 out_data,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   in_level,
   output logic [$clog2(DEPTH+1)-1:0]   out_level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, ACK} state_t;

   state_t          state_q;
   logic            io_ack_q;
   logic [N-1:0]    io_rdata_q;

   logic [N-1:0]    in_mem  [DEPTH];
   logic [N-1:0]    out_mem [DEPTH];
   logic [AW-1:0]   in_wp_q, in_rp_q, out_wp_q, out_rp_q;
   logic [LW-1:0]   in_lvl_q, out_lvl_q;
   logic [LW-1:0]   in_lvl_d, out_lvl_d;

   logic in_full, in_empty, out_full, out_empty;
   logic in_push, in_pop, out_push, out_pop;
   logic ior_go, iow_go;

   // Serviceability is decided purely from registered levels, never from same-cycle traffic.
   assign in_full   = (in_lvl_q == LVL_FULL);
   assign in_empty  = (in_lvl_q == '0);
   assign out_full  = (out_lvl_q == LVL_FULL);
   assign out_empty = (out_lvl_q == '0);

   assign ior_go = io_req && !in_empty &&
                   (((state_q == IDLE) && !io_we) || (state_q == RD_WAIT));
   assign iow_go = io_req && !out_full &&
                   (((state_q == IDLE) && io_we) || (state_q == WR_WAIT));

   assign in_push  = in_valid && !in_full;
   assign in_pop   = ior_go;
   assign out_push = iow_go;
   assign out_pop  = !out_empty && out_ready;

   assign in_lvl_d  = in_lvl_q  + LW'(in_push)  - LW'(in_pop);
   assign out_lvl_d = out_lvl_q + LW'(out_push) - LW'(out_pop);

   assign in_ready  = !in_full;
   assign out_valid = !out_empty;
   assign out_data  = out_empty ? '0 : out_mem[out_rp_q];
   assign in_level  = in_lvl_q;
   assign out_level = out_lvl_q;
   assign io_ack    = io_ack_q;
   assign io_rdata  = io_rdata_q;

   always_ff @(posedge clk) begin
      if (in_push)  in_mem[in_wp_q]   <= in_data;
      if (out_push) out_mem[out_wp_q] <= io_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_wp_q   <= '0;
         in_rp_q   <= '0;
         out_wp_q  <= '0;
         out_rp_q  <= '0;
         in_lvl_q  <= '0;
         out_lvl_q <= '0;
      end else begin
         if (in_push)  in_wp_q  <= in_wp_q  + AW'(1);
         if (in_pop)   in_rp_q  <= in_rp_q  + AW'(1);
         if (out_push) out_wp_q <= out_wp_q + AW'(1);
         if (out_pop)  out_rp_q <= out_rp_q + AW'(1);
         in_lvl_q  <= in_lvl_d;
         out_lvl_q <= out_lvl_d;
      end
   end

   // The ack pulse is registered: it rises exactly when a transfer moves the FSM into ACK.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         io_ack_q   <= 1'b0;
         io_rdata_q <= '0;
      end else begin
         io_ack_q <= ior_go || iow_go;
         if (ior_go) io_rdata_q <= in_mem[in_rp_q];
         case (state_q)
            IDLE: begin
               if (io_req) begin
                  if (io_we) state_q <= out_full ? WR_WAIT : ACK;
                  else       state_q <= in_empty ? RD_WAIT : ACK;
               end
            end
            RD_WAIT: begin
               if (!io_req)       state_q <= IDLE;
               else if (ior_go)   state_q <= ACK;
            end
            WR_WAIT: begin
               if (!io_req)       state_q <= IDLE;
               else if (iow_go)   state_q <= ACK;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mycpu_io_port.sv
// Directed bench for mycpu_io_port: a vector table for the IOR/IOW main flow plus
// hand-written sequences for stall, cancel, simultaneity and reset mid-handshake.
module tb_mycpu_io_port;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       io_req, io_we, io_ack;
   logic [7:0] io_wdata, io_rdata;
   logic       in_valid, in_ready;
   logic [7:0] in_data;
   logic       out_valid, out_ready;
   logic [7:0] out_data;
   logic [2:0] in_level, out_level;

   int total = 0;
   int bad   = 0;

   mycpu_io_port #(.N(8), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .io_req(io_req), .io_we(io_we), .io_wdata(io_wdata),
      .io_rdata(io_rdata), .io_ack(io_ack),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .in_level(in_level), .out_level(out_level)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       iv;
      logic [7:0] id;
      logic       rq;
      logic       we;
      logic [7:0] wd;
      logic       ordy;
      logic       ack;
      logic [7:0] rd;
      int         il;
      int         ol;
      logic [7:0] od;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic iv, input logic [7:0] id, input logic rq, input logic we,
                      input logic [7:0] wd, input logic ordy, input logic ack,
                      input logic [7:0] rd, input int il, input int ol, input logic [7:0] od);
      vec_t v;
      v.iv = iv; v.id = id; v.rq = rq; v.we = we; v.wd = wd; v.ordy = ordy;
      v.ack = ack; v.rd = rd; v.il = il; v.ol = ol; v.od = od;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic rq, input logic we, input logic [7:0] wd,
                        input logic iv, input logic [7:0] id, input logic ordy);
      io_req = rq; io_we = we; io_wdata = wd;
      in_valid = iv; in_data = id; out_ready = ordy;
   endtask

   task automatic check_all(input string tag, input logic ack, input logic [7:0] rd,
                            input int il, input int ol, input logic [7:0] od);
      chk({tag, ".ack"}, int'(io_ack), int'(ack));
      chk({tag, ".rdata"}, int'(io_rdata), int'(rd));
      chk({tag, ".in_level"}, int'(in_level), il);
      chk({tag, ".out_level"}, int'(out_level), ol);
      chk({tag, ".in_ready"}, int'(in_ready), int'(il != 4));
      chk({tag, ".out_valid"}, int'(out_valid), int'(ol != 0));
      chk({tag, ".out_data"}, int'(out_data), int'(od));
   endtask

   initial begin
      drive(0, 0, 8'h00, 0, 8'h00, 0);
      rst_n = 1'b0;

      // Main flow: IOR hit, then IOW fill to full, stall, wrap and drain.
      //   iv id     rq we wd     ordy ack rd     il ol od
      add(1, 8'h3C, 0, 0, 8'h00, 0,   0, 8'h00, 1, 0, 8'h00);
      add(1, 8'h91, 0, 0, 8'h00, 0,   0, 8'h00, 2, 0, 8'h00);
      add(0, 8'h00, 1, 0, 8'h00, 0,   1, 8'h3C, 1, 0, 8'h00);
      add(0, 8'h00, 0, 0, 8'h00, 0,   0, 8'h3C, 1, 0, 8'h00);
      add(0, 8'h00, 1, 0, 8'h00, 0,   1, 8'h91, 0, 0, 8'h00);
      add(0, 8'h00, 0, 0, 8'h00, 0,   0, 8'h91, 0, 0, 8'h00);
      add(0, 8'h00, 1, 1, 8'h01, 0,   1, 8'h91, 0, 1, 8'h01);
      add(0, 8'h00, 0, 1, 8'h01, 0,   0, 8'h91, 0, 1, 8'h01);
      add(0, 8'h00, 1, 1, 8'h02, 0,   1, 8'h91, 0, 2, 8'h01);
      add(0, 8'h00, 0, 1, 8'h02, 0,   0, 8'h91, 0, 2, 8'h01);
      add(0, 8'h00, 1, 1, 8'h03, 0,   1, 8'h91, 0, 3, 8'h01);
      add(0, 8'h00, 0, 1, 8'h03, 0,   0, 8'h91, 0, 3, 8'h01);
      add(0, 8'h00, 1, 1, 8'h04, 0,   1, 8'h91, 0, 4, 8'h01);
      add(0, 8'h00, 0, 1, 8'h04, 0,   0, 8'h91, 0, 4, 8'h01);
      add(0, 8'h00, 1, 1, 8'h05, 0,   0, 8'h91, 0, 4, 8'h01); // full: WR_WAIT
      add(0, 8'h00, 1, 1, 8'h05, 1,   0, 8'h91, 0, 3, 8'h02); // pop only, full was registered
      add(0, 8'h00, 1, 1, 8'h05, 0,   1, 8'h91, 0, 4, 8'h02); // push 0x05 on wrap
      add(0, 8'h00, 0, 1, 8'h05, 0,   0, 8'h91, 0, 4, 8'h02);
      add(0, 8'h00, 0, 0, 8'h00, 1,   0, 8'h91, 0, 3, 8'h03);
      add(0, 8'h00, 0, 0, 8'h00, 1,   0, 8'h91, 0, 2, 8'h04);
      add(0, 8'h00, 0, 0, 8'h00, 1,   0, 8'h91, 0, 1, 8'h05);
      add(0, 8'h00, 0, 0, 8'h00, 1,   0, 8'h91, 0, 0, 8'h00);

      // Reset values while held in reset.
      repeat (2) @(negedge clk);
      check_all("reset", 0, 8'h00, 0, 0, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);
      check_all("post_reset", 0, 8'h00, 0, 0, 8'h00);

      for (int k = 0; k < vecs.size(); k++) begin
         drive(vecs[k].rq, vecs[k].we, vecs[k].wd, vecs[k].iv, vecs[k].id, vecs[k].ordy);
         @(negedge clk);
         check_all($sformatf("vec%0d", k), vecs[k].ack, vecs[k].rd, vecs[k].il, vecs[k].ol, vecs[k].od);
         $display("vec %0d: ack=%0b rdata=%02h in_level=%0d out_level=%0d out_data=%02h",
                  k, io_ack, io_rdata, in_level, out_level, out_data);
      end

      // IOR stall on empty input FIFO, then fill.
      drive(1, 0, 8'h00, 0, 8'h00, 0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("stall%0d.ack", c), int'(io_ack), 0);
      end
      drive(1, 0, 8'h00, 1, 8'hA5, 0);          // push lands at edge e
      @(negedge clk);
      check_all("stall_push", 0, 8'h91, 1, 0, 8'h00);
      drive(1, 0, 8'h00, 0, 8'h00, 0);          // pop at edge e+1
      @(negedge clk);
      check_all("stall_ack", 1, 8'hA5, 0, 0, 8'h00);
      drive(0, 0, 8'h00, 0, 8'h00, 0);
      @(negedge clk);
      check_all("stall_done", 0, 8'hA5, 0, 0, 8'h00);
      $display("stall: rdata=%02h in_level=%0d", io_rdata, in_level);

      // Cancel from RD_WAIT.
      drive(1, 0, 8'h00, 0, 8'h00, 0);
      repeat (2) @(negedge clk);
      chk("cancel_wait.ack", int'(io_ack), 0);
      drive(0, 0, 8'h00, 0, 8'h00, 0);
      @(negedge clk);
      check_all("cancel", 0, 8'hA5, 0, 0, 8'h00);
      // Fill to level 2; an IDLE FSM leaves both entries in place.
      drive(0, 0, 8'h00, 1, 8'h11, 0);
      @(negedge clk);
      drive(0, 0, 8'h00, 1, 8'h22, 0);
      @(negedge clk);
      check_all("cancel_idle", 0, 8'hA5, 2, 0, 8'h00);
      // Producer push coincident with IOR pop at level 2.
      drive(1, 0, 8'h00, 1, 8'h33, 0);
      @(negedge clk);
      check_all("simul", 1, 8'h11, 2, 0, 8'h00);
      drive(0, 0, 8'h00, 0, 8'h00, 0);
      @(negedge clk);
      drive(1, 0, 8'h00, 0, 8'h00, 0);
      @(negedge clk);
      check_all("simul_next", 1, 8'h22, 1, 0, 8'h00);
      drive(0, 0, 8'h00, 0, 8'h00, 0);
      @(negedge clk);
      $display("simul: rdata=%02h in_level=%0d", io_rdata, in_level);

      // Reset mid-handshake: fill output FIFO, stall in WR_WAIT, then async reset.
      for (int w = 0; w < 4; w++) begin
         drive(1, 1, 8'(8'h40 + w), 0, 8'h00, 0);
         @(negedge clk);
         drive(0, 1, 8'h00, 0, 8'h00, 0);
         @(negedge clk);
      end
      drive(1, 1, 8'h50, 0, 8'h00, 0);
      repeat (2) @(negedge clk);
      check_all("wr_wait", 0, 8'h22, 1, 4, 8'h40);
      #2 rst_n = 1'b0;
      #1;
      check_all("async_rst", 0, 8'h00, 0, 0, 8'h00);
      drive(0, 0, 8'h00, 0, 8'h00, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check_all($sformatf("after_rst%0d", c), 0, 8'h00, 0, 0, 8'h00);
      end
      $display("reset mid-handshake: out_level=%0d out_valid=%0b", out_level, out_valid);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
